updown_sweep_ctrl: RTL
======================

# updown_sweep_ctrl

Sequencer that drives an up/down counter as a programmable triangle-wave (ping-pong) generator between a low and high limit. It accepts a start request with limits and a sweep count, runs the counter up and down the requested number of times (or continuously), and reports busy/done. It sits above the plain up/down counter and owns its direction (`m`) and reset/load sequencing, so downstream logic sees a clean, bounded count.

## Interface
- `W`, 8: counter/limit width.
- `NSW`, 4: sweep-count width.

- `c`  in  1  clock, rising edge.
- `r`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `stop`  in  1  abort; sampled only in UP/DOWN.
- `lo`  in  W  low limit, captured on accepted start.
- `hi`  in  W  high limit, captured on accepted start.
- `sweeps`  in  NSW  number of full sweeps (lo→hi→lo); 0 = continuous until `stop`.
- `q`  out  W  counter value.
- `m`  out  1  direction: 1 = counting up, 0 = counting down.
- `busy`  out  1  high in UP/DOWN.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  one-cycle pulse on rejected start.

## Operation
- States: IDLE, UP, DOWN, DONE.
- Reset (`r`=1 at an edge, any state): IDLE, `q`=0, `m`=1, `busy`=0, `done`=0, `err`=0, sweep counter 0, captured limits 0. Reset overrides all other inputs.
- IDLE: `q` holds. On `start`:
  - `lo < hi` (unsigned): capture `lo`/`hi`/`sweeps`, `q`←`lo`, →UP.
  - else: `err`=1 for the next cycle, stay IDLE, `q` unchanged.
- UP (`m`=1): `q`←`q`+1. When `q`==`hi`−1, `q`←`hi` and →DOWN.
- DOWN (`m`=0): `q`←`q`−1. When `q`==`lo`+1, `q`←`lo` and one sweep completes:
  - Finite mode and this is the last sweep: →DONE.
  - Otherwise (sweeps remain, or continuous): decrement the remaining count (finite mode only), →UP.
- `stop` in UP/DOWN: →DONE, `q` frozen at its current value. `stop` takes priority over a same-edge limit transition or sweep completion.
- DONE: `done`=1, `busy`=0, `q` holds. →IDLE unconditionally. `start` is ignored in DONE.
- `start` in UP/DOWN/DONE and `stop` in IDLE/DONE are ignored.
- `q` never leaves [`lo`,`hi`] while busy, so no modular wrap occurs. All compares are unsigned at width `W`.
- Inputs `lo`/`hi`/`sweeps` may change freely after capture without effect.

## Timing
- Start accepted at edge k: `q`=`lo`, `busy`=1 after edge k.
- With D = `hi`−`lo`:
  - Peak `q`=`hi` after edge k+D.
  - Back to `lo` after edge k+2D.
  - One sweep = 2D cycles, with no dwell at either limit.
- N finite sweeps: DONE (`done`=1, `q`=`lo`) after edge k+2ND; IDLE after edge k+2ND+1. `busy` is high for exactly 2ND cycles.
- `err` follows the sampling edge by one cycle, for one cycle.
- `stop` sampled at edge j: DONE after edge j, IDLE after edge j+1.

## Structure
- Package `updown_pkg`: state enum typedef (IDLE/UP/DOWN/DONE) and the default `W`/`NSW` localparams.
- Sub-module `updown_core`: W-bit counter with ports `c`, `r`, `en`, `ld`, `d`, `m`. Behaviour: load has priority over count; count up when `m`=1, down when `m`=0.
- The controller holds the FSM, the captured limits and the sweep counter, and drives `en`/`ld`/`m`.

## Test plan
- `lo`=3, `hi`=6, `sweeps`=2 → `q` = 3,4,5,6,5,4,3,4,5,6,5,4,3 on successive cycles. `done` pulses with `q`=3 after edge 12; `busy` high for 12 cycles.
- `lo`=5, `hi`=5 start → `err` is a one-cycle pulse; `busy` stays 0; `q` unchanged.
- `lo`=250, `hi`=255, `sweeps`=0; `stop` after 13 cycles → `q` peaks at 255 with no wrap, `done` asserts with `q` frozen, then IDLE.
- `lo`=0, `hi`=1, `sweeps`=3 → `q` = 0,1,0,1,0,1,0 with `m` = 1,0,1,0,1,0; `done` after edge 6.
- `start` pulsed while busy and during DONE → ignored, and the sequence is identical to an unperturbed run.
- `r` asserted mid-DOWN → next cycle `q`=0, `m`=1, IDLE, all flags 0. A following `start` runs normally.

Source files
------------

// File: rtl/updown_pkg.sv
// updown_pkg
// Shared definitions for the up/down sweep sequencer: default counter and
// sweep-count widths, and the controller state encoding.
package updown_pkg;

    localparam int W_DEF   = 8;   // counter / limit width
    localparam int NSW_DEF = 4;   // sweep-count width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : updown_pkg

// File: rtl/updown_core.sv
// updown_core
// Plain W-bit up/down counter. Load has priority over count; when counting,
// m=1 increments and m=0 decrements. Synchronous active-high reset to 0.
//
// Ports:
//   c   clock, rising edge
//   r   synchronous reset, active-high
//   en  count enable
//   ld  load d into the counter (overrides en)
//   d   load value
//   m   direction: 1 = up, 0 = down
//   q   counter value
module updown_core
    import updown_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         c,
    input  logic         r,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         m,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    // NOTE: sequential state is always assigned with non-blocking '<=' so
    // every flop samples the pre-edge values of its inputs.
    always_ff @(posedge c) begin
        if (r) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= m ? (q + ONE) : (q - ONE);
        end
    end

endmodule : updown_core

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
// Triangle-wave (ping-pong) sequencer on top of updown_core. A start in IDLE
// with lo < hi captures the limits and sweep count, loads q with lo and sweeps
// lo->hi->lo the requested number of times (0 = until stop). A start with
// lo >= hi is rejected with a one-cycle err pulse.
//
// Ports:
//   c       clock, rising edge
//   r       synchronous reset, active-high
//   start   start request (sampled in IDLE only)
//   stop    abort (sampled in UP/DOWN only), freezes q and goes to DONE
//   lo, hi  sweep limits, captured on an accepted start
//   sweeps  number of full sweeps, 0 = continuous
//   q       counter value
//   m       direction: 1 = up, 0 = down
//   busy    high while sweeping (UP/DOWN)
//   done    one-cycle pulse in DONE
//   err     one-cycle pulse after a rejected start
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int NSW = NSW_DEF
) (
    input  logic           c,
    input  logic           r,
    input  logic           start,
    input  logic           stop,
    input  logic [W-1:0]   lo,
    input  logic [W-1:0]   hi,
    input  logic [NSW-1:0] sweeps,
    output logic [W-1:0]   q,
    output logic           m,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [W-1:0]   ONE    = W'(1);
    localparam logic [NSW-1:0] SW_ONE = NSW'(1);

    state_t         state, state_d;
    logic [W-1:0]   lo_q, hi_q;
    logic [NSW-1:0] sw_left;     // remaining sweeps; 0 means continuous
    logic           err_q;

    logic           en, ld, cap, sw_dec, err_d;
    logic           at_top, at_bottom;

    // Turnaround is decided one step early so q lands exactly on the limit
    // in the same edge that flips direction: no dwell at either end.
    assign at_top    = (q == (hi_q - ONE));
    assign at_bottom = (q == (lo_q + ONE));

    assign m    = (state != ST_DOWN);
    assign busy = (state == ST_UP) || (state == ST_DOWN);
    assign done = (state == ST_DONE);
    assign err  = err_q;

    always_ff @(posedge c) begin
        if (r) begin
            state   <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            sw_left <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= err_d;
            if (cap) begin
                lo_q    <= lo;
                hi_q    <= hi;
                sw_left <= sweeps;
            end else if (sw_dec) begin
                sw_left <= sw_left - SW_ONE;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        en      = 1'b0;
        ld      = 1'b0;
        cap     = 1'b0;
        sw_dec  = 1'b0;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        cap     = 1'b1;
                        ld      = 1'b1;
                        state_d = ST_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_d = ST_DONE;      // q frozen: en stays low
                end else begin
                    en = 1'b1;
                    if (at_top) state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else begin
                    en = 1'b1;
                    if (at_bottom) begin
                        if (sw_left == SW_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_UP;
                            sw_dec  = (sw_left != '0);  // continuous never counts
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    updown_core #(.W(W)) u_core (
        .c  (c),
        .r  (r),
        .en (en),
        .ld (ld),
        .d  (lo),
        .m  (m),
        .q  (q)
    );

endmodule : updown_sweep_ctrl
